// File: rtl/apb_dma_if.sv
// APB initiator bus bundle used by apb_dma.
// The master modport is the DMA side; the slave modport is the responder side.
interface apb_dma_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [3:0]            pstb;
   logic                  pready;
   logic                  perr;

   modport master (
      output paddr, pdata, psel, penable, pwrite, pstb,
      input  prdata, pready, perr
   );

   modport slave (
      input  paddr, pdata, psel, penable, pwrite, pstb,
      output prdata, pready, perr
   );
endinterface

// File: rtl/apb_dma.sv
// apb_dma: single-channel word-copy DMA acting as an APB initiator.
// Each word is one read transfer followed by one write transfer.
// Optional feature: define APB_TIMEOUT_EN to abort a job when an access phase
// waits TIMEOUT_CYCLES cycles without pready.
module apb_dma #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  APB_PRESETn,
   input  logic [ADDR_WIDTH-1:0] cfg_src,
   input  logic [ADDR_WIDTH-1:0] cfg_dst,
   input  logic [15:0]           cfg_len,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           remaining,
   apb_dma_if.master             DMA
);

   typedef enum logic [2:0] {
      IDLE,
      RD_SETUP,
      RD_ACCESS,
      WR_SETUP,
      WR_ACCESS,
      FINISH
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] WordStep  = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(3);

   state_t                r_state;
   state_t                w_nextState;
   logic [ADDR_WIDTH-1:0] r_src;
   logic [ADDR_WIDTH-1:0] r_dst;
   logic [DATA_WIDTH-1:0] r_buf;
   logic [15:0]           r_remaining;
   logic                  r_err;

   logic w_accept;
   logic w_capture;
   logic w_wordDone;
   logic w_busErr;
   logic w_timeout;
   logic w_rdPhase;
   logic w_wrPhase;
   logic w_access;
   logic w_setup;

   assign w_accept  = (r_state == IDLE) && start;
   assign w_rdPhase = (r_state == RD_SETUP) || (r_state == RD_ACCESS);
   assign w_wrPhase = (r_state == WR_SETUP) || (r_state == WR_ACCESS);
   assign w_access  = (r_state == RD_ACCESS) || (r_state == WR_ACCESS);
   assign w_setup   = (r_state == RD_SETUP) || (r_state == WR_SETUP);

`ifdef APB_TIMEOUT_EN
   localparam int WaitWidth = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [WaitWidth-1:0] r_waitCnt;
   logic                 w_waitExpired;

   // The last tolerated wait cycle is the one where the count already equals TIMEOUT_CYCLES-1.
   assign w_waitExpired = w_access && !DMA.pready && (r_waitCnt == WaitWidth'(TIMEOUT_CYCLES - 1));

   // Count consecutive stalled access cycles, restarting at every setup phase.
   always_ff @(posedge clk or negedge APB_PRESETn) begin
      if (!APB_PRESETn) begin
         r_waitCnt <= '0;
      end else if (w_setup) begin
         r_waitCnt <= '0;
      end else if (w_access && !DMA.pready) begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end
   end
`else
   logic w_waitExpired;

   assign w_waitExpired = 1'b0;
`endif

   // State register; reset abandons any job in flight without a done pulse.
   always_ff @(posedge clk or negedge APB_PRESETn) begin
      if (!APB_PRESETn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode plus the per-cycle events that steer the datapath.
   always_comb begin
      w_nextState = r_state;
      w_capture   = 1'b0;
      w_wordDone  = 1'b0;
      w_busErr    = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = (cfg_len != 16'd0) ? RD_SETUP : FINISH;
            end
         end
         RD_SETUP: begin
            w_nextState = RD_ACCESS;
         end
         RD_ACCESS: begin
            if (DMA.pready) begin
               if (DMA.perr) begin
                  w_busErr    = 1'b1;
                  w_nextState = FINISH;
               end else begin
                  w_capture   = 1'b1;
                  w_nextState = WR_SETUP;
               end
            end else if (w_waitExpired) begin
               w_timeout   = 1'b1;
               w_nextState = FINISH;
            end
         end
         WR_SETUP: begin
            w_nextState = WR_ACCESS;
         end
         WR_ACCESS: begin
            if (DMA.pready) begin
               if (DMA.perr) begin
                  w_busErr    = 1'b1;
                  w_nextState = FINISH;
               end else begin
                  w_wordDone  = 1'b1;
                  w_nextState = (r_remaining == 16'd1) ? FINISH : RD_SETUP;
               end
            end else if (w_waitExpired) begin
               w_timeout   = 1'b1;
               w_nextState = FINISH;
            end
         end
         FINISH: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Job registers: latch the configuration on start, advance only on a clean write.
   always_ff @(posedge clk or negedge APB_PRESETn) begin
      if (!APB_PRESETn) begin
         r_src       <= '0;
         r_dst       <= '0;
         r_buf       <= '0;
         r_remaining <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_src       <= cfg_src & AlignMask;
            r_dst       <= cfg_dst & AlignMask;
            r_remaining <= cfg_len;
            r_err       <= 1'b0;
         end
         if (w_capture) begin
            r_buf <= DMA.prdata;
         end
         if (w_wordDone) begin
            r_src       <= r_src + WordStep;
            r_dst       <= r_dst + WordStep;
            r_remaining <= r_remaining - 16'd1;
         end
         if (w_busErr || w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   // Bus controls are decoded straight from the state so reset drops them immediately.
   always_comb begin
      DMA.psel    = w_rdPhase || w_wrPhase;
      DMA.penable = w_access;
      DMA.pwrite  = w_wrPhase;
      DMA.pstb    = (w_rdPhase || w_wrPhase) ? 4'b1111 : 4'b0000;
      DMA.paddr   = '0;
      DMA.pdata   = '0;
      if (w_rdPhase) begin
         DMA.paddr = r_src;
      end else if (w_wrPhase) begin
         DMA.paddr = r_dst;
         DMA.pdata = r_buf;
      end
   end

   assign busy      = (r_state != IDLE);
   assign done      = (r_state == FINISH);
   assign err       = r_err;
   assign remaining = r_remaining;

endmodule

// File: tb/tb_apb_dma.sv
// Testbench for apb_dma: a memory responder with programmable wait states and
// error injection, plus a word-level copy model that predicts memory contents,
// job latency and final status.
module tb_apb_dma;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int Timeout = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] cfg_src;
   logic [AW-1:0] cfg_dst;
   logic [15:0]   cfg_len;
   logic          start;
   logic          busy;
   logic          done;
   logic          err;
   logic [15:0]   remaining;

   int checks = 0;
   int fails  = 0;

   // Responder configuration and statistics.
   int waitCfg      = 0;
   int errOnRead    = 0;
   bit stallForever = 1'b0;
   int readCount    = 0;
   int writeCount   = 0;
   int waitCount    = 0;
   int unstable     = 0;
   int badStrobe    = 0;
   logic [31:0] snapAddr;
   logic [31:0] snapData;
   logic        snapWrite;

   logic [31:0] mem   [logic [31:0]];
   logic [31:0] model [logic [31:0]];

   apb_dma_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_dma #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(Timeout)
   ) dut (
      .clk(clk),
      .APB_PRESETn(rst_n),
      .cfg_src(cfg_src),
      .cfg_dst(cfg_dst),
      .cfg_len(cfg_len),
      .start(start),
      .busy(busy),
      .done(done),
      .err(err),
      .remaining(remaining),
      .DMA(bus)
   );

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   // Memory responder: decides pready/perr on the falling edge of every access cycle.
   initial begin
      bus.pready = 1'b0;
      bus.perr   = 1'b0;
      bus.prdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.pready = 1'b0;
            bus.perr   = 1'b0;
            waitCount  = 0;
         end else if (bus.psel && bus.penable) begin
            if (bus.pstb !== 4'hF) badStrobe++;
            if (waitCount == 0) begin
               snapAddr  = bus.paddr;
               snapData  = bus.pdata;
               snapWrite = bus.pwrite;
            end else if (bus.paddr !== snapAddr || bus.pdata !== snapData || bus.pwrite !== snapWrite) begin
               unstable++;
            end
            if (stallForever || waitCount < waitCfg) begin
               bus.pready = 1'b0;
               bus.perr   = 1'b0;
            end else begin
               bus.pready = 1'b1;
               if (!bus.pwrite) begin
                  readCount++;
                  bus.perr   = (readCount == errOnRead);
                  bus.prdata = mem.exists(bus.paddr) ? mem[bus.paddr] : 32'hDEAD_BEEF;
               end else begin
                  bus.perr = 1'b0;
                  mem[bus.paddr] = bus.pdata;
                  writeCount++;
               end
            end
            waitCount++;
         end else begin
            bus.pready = 1'b0;
            bus.perr   = 1'b0;
            waitCount  = 0;
         end
      end
   end

   function automatic logic [31:0] memAt(logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic loadWords(logic [31:0] src, int len);
      logic [31:0] a;
      logic [31:0] w;
      for (int i = 0; i < len; i++) begin
         a = (src & ~32'h3) + 32'(4 * i);
         w = $urandom;
         mem[a]   = w;
         model[a] = w;
      end
   endtask

   // Pulse start for one cycle, then scramble cfg to show it is only sampled on start.
   task automatic applyStimulus(logic [31:0] src, logic [31:0] dst, logic [15:0] len);
      readCount  = 0;
      writeCount = 0;
      unstable   = 0;
      badStrobe  = 0;
      @(negedge clk);
      cfg_src = src;
      cfg_dst = dst;
      cfg_len = len;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      cfg_src = $urandom;
      cfg_dst = $urandom;
      cfg_len = 16'($urandom);
   endtask

   // Step cycle by cycle until done, bounded; n counts edges after the start edge.
   task automatic waitDone(string tag, int budget, output int n, output int busyLow, output int pselSeen);
      n = 0;
      busyLow = 0;
      pselSeen = 0;
      while (!done && n < budget) begin
         if (!busy) busyLow++;
         if (bus.psel) pselSeen++;
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({tag, ".doneSeen"}, done, 1);
      checkOutput({tag, ".busyAtDone"}, busy, 1);
      checkOutput({tag, ".pselInFinish"}, bus.psel, 0);
   endtask

   task automatic checkDoneFalls(string tag);
      @(posedge clk);
      #1;
      checkOutput({tag, ".donePulseOneCycle"}, done, 0);
      checkOutput({tag, ".idleNotBusy"}, busy, 0);
   endtask

   task automatic runCopy(string tag, logic [31:0] src, logic [31:0] dst, int len, int waits);
      logic [31:0] s;
      logic [31:0] d;
      int n;
      int busyLow;
      int pselSeen;
      int expN;
      s = src & ~32'h3;
      d = dst & ~32'h3;
      for (int i = 0; i < len; i++) model[d + 32'(4 * i)] = model[s + 32'(4 * i)];
      expN = 4 * len + 2 * waits * len;
      waitCfg   = waits;
      errOnRead = 0;
      applyStimulus(src, dst, 16'(len));
      checkOutput({tag, ".busyAfterStart"}, busy, 1);
      checkOutput({tag, ".errCleared"}, err, 0);
      checkOutput({tag, ".remainingLatched"}, remaining, 32'(len));
      waitDone(tag, expN + 20, n, busyLow, pselSeen);
      checkOutput({tag, ".jobCycles"}, 32'(n + 2), 32'(expN + 2));
      checkOutput({tag, ".err"}, err, 0);
      checkOutput({tag, ".remaining"}, remaining, 0);
      checkOutput({tag, ".busyHeld"}, 32'(busyLow), 0);
      checkOutput({tag, ".reads"}, 32'(readCount), 32'(len));
      checkOutput({tag, ".writes"}, 32'(writeCount), 32'(len));
      checkOutput({tag, ".stableInWait"}, 32'(unstable), 0);
      checkOutput({tag, ".strobe"}, 32'(badStrobe), 0);
      for (int i = 0; i < len; i++) begin
         checkOutput({tag, ".dstWord"}, memAt(d + 32'(4 * i)), model[d + 32'(4 * i)]);
      end
      checkDoneFalls(tag);
   endtask

   // Directed sequence followed by randomized copies against the word model.
   initial begin
      int n;
      int busyLow;
      int pselSeen;
      int k;
      int doneSeen;
      logic [31:0] rs;
      logic [31:0] rd;
      int rl;
      int rw;

      rst_n   = 1'b0;
      start   = 1'b0;
      cfg_src = '0;
      cfg_dst = '0;
      cfg_len = '0;

      $display("[TB] reset values");
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.psel", bus.psel, 0);
      checkOutput("rst.penable", bus.penable, 0);
      checkOutput("rst.pwrite", bus.pwrite, 0);
      checkOutput("rst.busy", busy, 0);
      checkOutput("rst.done", done, 0);
      checkOutput("rst.err", err, 0);
      checkOutput("rst.paddr", bus.paddr, 0);
      checkOutput("rst.pdata", bus.pdata, 0);
      checkOutput("rst.pstb", 32'(bus.pstb), 0);
      checkOutput("rst.remaining", remaining, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] basic copy");
      mem[32'h100] = 32'hA; model[32'h100] = 32'hA;
      mem[32'h104] = 32'hB; model[32'h104] = 32'hB;
      mem[32'h108] = 32'hC; model[32'h108] = 32'hC;
      runCopy("basic", 32'h100, 32'h200, 3, 0);
      checkOutput("basic.word0", memAt(32'h200), 32'hA);
      checkOutput("basic.word2", memAt(32'h208), 32'hC);

      $display("[TB] zero length");
      waitCfg = 0;
      applyStimulus(32'h300, 32'h400, 16'd0);
      waitDone("len0", 10, n, busyLow, pselSeen);
      checkOutput("len0.jobCycles", 32'(n + 2), 2);
      checkOutput("len0.pselNever", 32'(pselSeen), 0);
      checkOutput("len0.reads", 32'(readCount), 0);
      checkDoneFalls("len0");

      $display("[TB] wait states");
      loadWords(32'h500, 2);
      runCopy("waits", 32'h500, 32'h600, 2, 3);

      $display("[TB] bus error on second read");
      loadWords(32'h700, 4);
      model[32'h800] = model[32'h700];
      waitCfg   = 0;
      errOnRead = 2;
      applyStimulus(32'h700, 32'h800, 16'd4);
      waitDone("berr", 40, n, busyLow, pselSeen);
      checkOutput("berr.jobCycles", 32'(n + 2), 32'(4 * 1 + 2 + 2));
      checkOutput("berr.err", err, 1);
      checkOutput("berr.remaining", remaining, 3);
      checkOutput("berr.writes", 32'(writeCount), 1);
      checkOutput("berr.word0", memAt(32'h800), model[32'h800]);
      checkOutput("berr.word1Unwritten", 32'(mem.exists(32'h804)), 0);
      checkDoneFalls("berr");
      checkOutput("berr.errSticky", err, 1);
      errOnRead = 0;
      runCopy("afterErr", 32'h700, 32'h900, 1, 0);

      $display("[TB] asynchronous reset mid-write");
      loadWords(32'hA00, 2);
      waitCfg = 2;
      applyStimulus(32'hA00, 32'hB00, 16'd2);
      k = 0;
      while (!(bus.psel && bus.penable && bus.pwrite) && k < 30) begin
         @(posedge clk);
         #1;
         k++;
      end
      checkOutput("arst.reachedWrAccess", 32'(bus.penable & bus.pwrite), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst.psel", bus.psel, 0);
      checkOutput("arst.penable", bus.penable, 0);
      checkOutput("arst.pwrite", bus.pwrite, 0);
      checkOutput("arst.busy", busy, 0);
      checkOutput("arst.done", done, 0);
      checkOutput("arst.paddr", bus.paddr, 0);
      checkOutput("arst.pdata", bus.pdata, 0);
      checkOutput("arst.pstb", 32'(bus.pstb), 0);
      checkOutput("arst.remaining", remaining, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("arst.noDone", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      loadWords(32'hC00, 3);
      runCopy("afterRst", 32'hC00, 32'hD00, 3, 1);

      $display("[TB] address wrap and unaligned cfg");
      loadWords(32'hFFFF_FFF8, 3);
      runCopy("wrap", 32'hFFFF_FFFB, 32'h0000_1001, 3, 0);

      $display("[TB] randomized copies");
      for (int j = 0; j < 6; j++) begin
         rs = $urandom;
         rd = $urandom;
         rl = $urandom_range(1, 6);
         rw = $urandom_range(0, 3);
         loadWords(rs, rl);
         runCopy("rand", rs, rd, rl, rw);
      end

`ifdef APB_TIMEOUT_EN
      $display("[TB] access timeout");
      loadWords(32'h2000, 1);
      stallForever = 1'b1;
      applyStimulus(32'h2000, 32'h3000, 16'd1);
      waitDone("tmo", 100, n, busyLow, pselSeen);
      checkOutput("tmo.doneCycle", 32'(n), 32'(1 + Timeout));
      checkOutput("tmo.err", err, 1);
      checkOutput("tmo.remaining", remaining, 1);
      checkOutput("tmo.writes", 32'(writeCount), 0);
      checkDoneFalls("tmo");
      stallForever = 1'b0;
`else
      $display("[TB] indefinite wait without timeout");
      loadWords(32'h2000, 1);
      stallForever = 1'b1;
      applyStimulus(32'h2000, 32'h3000, 16'd1);
      busyLow  = 0;
      doneSeen = 0;
      for (int c = 0; c < 1005; c++) begin
         @(posedge clk);
         #1;
         if (!busy) busyLow++;
         if (done) doneSeen++;
      end
      checkOutput("stall.busyHeld", 32'(busyLow), 0);
      checkOutput("stall.noDone", 32'(doneSeen), 0);
      checkOutput("stall.stillAccess", bus.penable, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("stall.resetDropsPsel", bus.psel, 0);
      @(negedge clk);
      rst_n = 1'b1;
      stallForever = 1'b0;
`endif

      loadWords(32'h4000, 2);
      runCopy("final", 32'h4000, 32'h5000, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/apb_dma.md
# apb_dma

Single-channel word-copy DMA engine that acts as an APB initiator. It is the other end of the peripheral bus: it drives paddr/psel/penable/pwrite/pstb/pdata and consumes pready/perr/prdata, with the same semantics the sram/uart/timer/intctrl responders already implement. It copies `cfg_len` 32-bit words from a source to a destination address, one read transfer followed by one write transfer per word. It sits beside `cpu` as a second bus master; the arbiter in front of `APB` is a separate block.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width; fixed at 32 for this block.
- `TIMEOUT_CYCLES`, default 255: maximum access-phase wait cycles; used only with `APB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `APB_PRESETn` in 1: reset, asynchronous, active-low.
- `cfg_src` in ADDR_WIDTH: source byte address; bits [1:0] are ignored and forced to 0.
- `cfg_dst` in ADDR_WIDTH: destination byte address; bits [1:0] are forced to 0.
- `cfg_len` in 16: word count; 0 is legal.
- `start` in 1: single-cycle request, sampled in IDLE only.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at the end of a job (success or error).
- `err` out 1: sticky error flag; cleared by the next accepted `start`.
- `remaining` out 16: words not yet written.
- `DMA_paddr` out ADDR_WIDTH; `DMA_pdata` out DATA_WIDTH; `DMA_prdata` in DATA_WIDTH.
- `DMA_psel` out 1; `DMA_penable` out 1; `DMA_pwrite` out 1; `DMA_pstb` out 4.
- `DMA_pready` in 1; `DMA_perr` in 1.

## Operation
- States: IDLE, RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS, FINISH.
- IDLE with `start`=1: latch `src`, `dst` and `len` into internal registers, clear `err`, then:
  - len≠0 → RD_SETUP.
  - len=0 → FINISH, with no bus activity.
- RD_SETUP: psel=1, penable=0, pwrite=0, paddr=src, pstb=4'b1111. Next state is RD_ACCESS unconditionally.
- RD_ACCESS: psel=1, penable=1, all address/control outputs held.
  - On pready && !perr: capture prdata into the data buffer → WR_SETUP.
- WR_SETUP: psel=1, penable=0, pwrite=1, paddr=dst, pdata=buffer, pstb=4'b1111. Next state is WR_ACCESS.
- WR_ACCESS: held until pready.
  - On pready && !perr: src+=4, dst+=4, remaining-=1.
  - Then → RD_SETUP if remaining≠0 after the decrement, else → FINISH.
- pready && perr in either ACCESS state → FINISH with err=1. The failed word is not counted and the addresses are not advanced.
- FINISH: `done`=1 for one cycle → IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap from 0xFFFFFFFC to 0x00000000 is silent.
- `start` while not in IDLE is ignored, with no effect on the latched configuration.
- `cfg_*` inputs are don't-care outside the `start` cycle.

## Timing
- Reset values:
  - psel, penable, pwrite, busy, done, err = 0.
  - paddr, pdata = 0; pstb = 0; remaining = 0.
  - State is IDLE.
- Reset is asynchronous: asserting it mid-transfer drops psel/penable immediately and abandons the job. No `done` is produced.
- `start` at edge N → RD_SETUP visible in cycle N+1, with busy=1.
- With zero-wait responders, each word takes 4 cycles. Total job = 4·len + 2 cycles from `start` to the end of the `done` pulse.
- Each wait state (pready=0 in an ACCESS state) adds one cycle. All bus outputs are stable during waits.
- psel never deasserts between SETUP and the completing ACCESS.
- psel drops to 0 in FINISH and IDLE.
- `remaining` updates on the WR_ACCESS completion edge.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - An 8-bit-minimum counter counts consecutive ACCESS cycles with pready=0.
  - When the count reaches TIMEOUT_CYCLES: psel/penable drop, err=1, → FINISH.
  - The counter clears on every SETUP.
- `APB_TIMEOUT_EN` undefined:
  - The counter is absent.
  - The engine waits indefinitely for pready.

## Test plan
- Basic copy: src=0x100, dst=0x200, len=3, zero-wait sram holding 0xA, 0xB, 0xC.
  - Required: 0x200..0x208 = A, B, C.
  - done pulses exactly 14 cycles after start.
  - err=0, remaining=0.
- len=0: start → done pulses 2 cycles later, psel never asserts, busy high for 1 cycle.
- Wait states: responder holds pready=0 for 3 cycles on each access, len=2.
  - Required: total 8+12+2=22 cycles.
  - paddr/pdata/pwrite stable throughout each wait.
- Bus error: perr=1 on the second read, len=4.
  - Required: err=1, remaining=3, only one write issued, done pulses once.
  - A following start clears err.
- Async reset: deassert APB_PRESETn during the WR_ACCESS of word 1.
  - Required: psel=0 in the same timestep, all outputs at reset values.
  - A new job runs normally afterwards.
- Timeout (`APB_TIMEOUT_EN`, TIMEOUT_CYCLES=16): pready tied 0.
  - Required: err=1 and done 16 cycles into RD_ACCESS.
  - Without the macro, busy stays 1 for more than 1000 cycles.
